// File: rtl/spi_slave_responder_pkg.sv
// Shared definitions for the SPI responder: FSM state encoding.
package spi_slave_responder_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_slave_responder_sync.sv
// Single-bit multi-flop synchronizer with a selectable reset value.
module spi_slave_responder_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) chain <= {STAGES{RESET_VAL}};
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0, LSB-first target oversampled in the clk domain, with a one-word tx holding register.
// state  | meaning
// IDLE   | cs high; waits for select, then loads the first tx word
// ACTIVE | frame in progress; sample on SCLK rise, shift/reload on SCLK fall
module spi_slave_responder
    import spi_slave_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    state_t         state, state_next;
    logic           sclk_s, cs_s, mosi_s, sclk_d;
    logic           rise, fall;
    logic [W-1:0]   tx_shift, tx_shift_next;
    logic [W-2:0]   rx_part, rx_part_next;
    logic [W-1:0]   rx_word, rx_data_next, hold_data;
    logic           hold_full, consume;
    logic [CW-1:0]  bit_cnt, bit_cnt_next;
    logic           seen_rise, seen_rise_next;
    logic           rx_valid_next, tx_underrun_next, frame_error_next;

    spi_slave_responder_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk), .q(sclk_s));
    spi_slave_responder_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(cs_n), .q(cs_s));
    spi_slave_responder_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(mosi), .q(mosi_s));

    assign rise    = sclk_s & ~sclk_d;
    assign fall    = ~sclk_s & sclk_d;
    assign rx_word = {mosi_s, rx_part};

    always_comb begin
        state_next       = state;
        tx_shift_next    = tx_shift;
        rx_part_next     = rx_part;
        rx_data_next     = rx_data;
        bit_cnt_next     = bit_cnt;
        seen_rise_next   = seen_rise;
        rx_valid_next    = 1'b0;
        tx_underrun_next = 1'b0;
        frame_error_next = 1'b0;
        consume          = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_s) begin
                    consume          = 1'b1;
                    tx_shift_next    = hold_full ? hold_data : '0;
                    tx_underrun_next = ~hold_full;
                    bit_cnt_next     = '0;
                    seen_rise_next   = 1'b0;
                    state_next       = ACTIVE;
                end
            end
            ACTIVE: begin
                // Deselect has priority over a coincident rise, so that bit is dropped.
                if (cs_s) begin
                    state_next       = IDLE;
                    frame_error_next = (bit_cnt != '0);
                end else if (rise) begin
                    rx_part_next   = rx_word[W-1:1];
                    seen_rise_next = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        rx_data_next  = rx_word;
                        rx_valid_next = 1'b1;
                        bit_cnt_next  = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + CW'(1);
                    end
                end else if (fall && seen_rise) begin
                    if (bit_cnt == '0) begin
                        consume          = 1'b1;
                        tx_shift_next    = hold_full ? hold_data : '0;
                        tx_underrun_next = ~hold_full;
                    end else begin
                        tx_shift_next = {1'b0, tx_shift[W-1:1]};
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sclk_d      <= 1'b0;
            tx_shift    <= '0;
            rx_part     <= '0;
            rx_data     <= '0;
            bit_cnt     <= '0;
            seen_rise   <= 1'b0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            sclk_d      <= sclk_s;
            tx_shift    <= tx_shift_next;
            rx_part     <= rx_part_next;
            rx_data     <= rx_data_next;
            bit_cnt     <= bit_cnt_next;
            seen_rise   <= seen_rise_next;
            rx_valid    <= rx_valid_next;
            tx_underrun <= tx_underrun_next;
            frame_error <= frame_error_next;
        end
    end

    // A write can only coincide with a consume while empty; the new word then survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end else if (consume) begin
            hold_full <= 1'b0;
        end
    end

    assign tx_ready = ~hold_full;
    assign miso     = tx_shift[0];
    assign miso_oe  = ~cs_s;
    assign busy     = (state != IDLE);

endmodule
